// File: rtl/ps2_rx_nibbler.sv
// ps2_rx_nibbler
//   Receives PS/2 keyboard frames from the raw ps2_clk/ps2_data pins and turns
//   them into scan-code bytes. Each good byte is also presented as two nibbles
//   (high, then low) on consecutive cycles for the seven-segment debug display.
//
// Ports
//   clk         system clock
//   rst         synchronous active-high reset
//   ps2_clk     raw PS/2 clock pin (asynchronous)
//   ps2_data    raw PS/2 data pin (asynchronous)
//   byte_out    last good scan-code byte, held until the next good frame
//   byte_valid  one-cycle pulse when byte_out updates
//   nib         display nibble, holds its value while nib_valid is low
//   nib_valid   one-cycle nibble strobe (display enable)
//   err_parity  one-cycle pulse on odd-parity failure
//   err_frame   one-cycle pulse on bad stop bit or inter-edge timeout
//
// Build option
//   PS2_RX_BREAK_FILTER_EN: when defined, a break prefix (0xF0) and the byte
//   following it produce byte_valid only, so the display shows make codes only.

module ps2_rx_nibbler #(
    parameter int unsigned FILTER_LEN     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] byte_out,
    output logic       byte_valid,
    output logic [3:0] nib,
    output logic       nib_valid,
    output logic       err_parity,
    output logic       err_frame
);

    localparam int unsigned FW = $clog2(FILTER_LEN + 1);
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_LEN - 1);
    localparam logic [TW-1:0] TMO_MAX   = TW'(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        IDLE,
        DATA,
        PARITY,
        STOP,
        EMIT_HI,
        EMIT_LO
    } state_t;

    state_t state, state_n;

    logic          clk_s1, clk_s2, data_s1, data_s2;
    logic          filt, filt_d;
    logic [FW-1:0] fcnt;
    logic          fall;

    logic [3:0]    bit_cnt;
    logic [7:0]    shift;
    logic          par_bit;
    logic          par_ok;
    logic [TW-1:0] tmo;
    logic          tmo_hit;
    logic          in_frame, in_frame_n;

    logic          go_emit, err_par_n, err_frm_n;
    logic          quiet_n, quiet_q;

    // Synchronizers and glitch filter. The filtered clock only follows the
    // synchronized pin after FILTER_LEN consecutive samples of the new level.
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_s1  <= 1'b1;
            clk_s2  <= 1'b1;
            data_s1 <= 1'b1;
            data_s2 <= 1'b1;
            filt    <= 1'b1;
            filt_d  <= 1'b1;
            fcnt    <= '0;
        end else begin
            clk_s1  <= ps2_clk;
            clk_s2  <= clk_s1;
            data_s1 <= ps2_data;
            data_s2 <= data_s1;
            filt_d  <= filt;
            if (clk_s2 == filt) begin
                fcnt <= '0;
            end else if (fcnt == FILT_LAST) begin
                filt <= clk_s2;
                fcnt <= '0;
            end else begin
                fcnt <= fcnt + FW'(1);
            end
        end
    end

    assign fall       = filt_d & ~filt;
    assign par_ok     = ^{shift, par_bit};
    assign tmo_hit    = (tmo == TMO_MAX);
    assign in_frame   = state inside {DATA, PARITY, STOP};
    assign in_frame_n = state_n inside {DATA, PARITY, STOP};

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n   = state;
        go_emit   = 1'b0;
        err_par_n = 1'b0;
        err_frm_n = 1'b0;
        case (state)
            IDLE: begin
                if (fall && !data_s2) begin
                    state_n = DATA;
                end
            end
            DATA: begin
                if (fall && bit_cnt == 4'd7) begin
                    state_n = PARITY;
                end
            end
            PARITY: begin
                if (fall) begin
                    state_n = STOP;
                end
            end
            STOP: begin
                if (fall) begin
                    // A bad stop bit is reported even when parity also failed.
                    if (!data_s2) begin
                        err_frm_n = 1'b1;
                        state_n   = IDLE;
                    end else if (!par_ok) begin
                        err_par_n = 1'b1;
                        state_n   = IDLE;
                    end else begin
                        go_emit = 1'b1;
                        state_n = EMIT_HI;
                    end
                end
            end
            EMIT_HI: state_n = EMIT_LO;
            EMIT_LO: state_n = IDLE;
            default: state_n = IDLE;
        endcase
        // An edge on the same cycle restarts the interval, so it wins.
        if (in_frame && !fall && tmo_hit) begin
            err_frm_n = 1'b1;
            state_n   = IDLE;
        end
    end

`ifdef PS2_RX_BREAK_FILTER_EN
    logic suppress;

    assign quiet_n = suppress || (shift == 8'hF0);

    always_ff @(posedge clk) begin
        if (rst) begin
            suppress <= 1'b0;
            quiet_q  <= 1'b0;
        end else if (go_emit) begin
            quiet_q  <= quiet_n;
            suppress <= (shift == 8'hF0);
        end
    end
`else
    assign quiet_n = 1'b0;
    assign quiet_q = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt    <= '0;
            shift      <= '0;
            par_bit    <= 1'b0;
            tmo        <= '0;
            byte_out   <= '0;
            byte_valid <= 1'b0;
            nib        <= '0;
            nib_valid  <= 1'b0;
            err_parity <= 1'b0;
            err_frame  <= 1'b0;
        end else begin
            if (state == IDLE && fall && !data_s2) begin
                bit_cnt <= '0;
            end
            if (state == DATA && fall) begin
                shift   <= {data_s2, shift[7:1]};
                bit_cnt <= bit_cnt + 4'd1;
            end
            if (state == PARITY && fall) begin
                par_bit <= data_s2;
            end

            if (!in_frame_n || fall) begin
                tmo <= '0;
            end else if (!tmo_hit) begin
                tmo <= tmo + TW'(1);
            end

            byte_valid <= go_emit;
            err_parity <= err_par_n;
            err_frame  <= err_frm_n;
            nib_valid  <= (go_emit && !quiet_n) || (state == EMIT_HI && !quiet_q);

            if (go_emit) begin
                byte_out <= shift;
            end
            // byte_out already holds the new byte while in EMIT_HI.
            if (go_emit && !quiet_n) begin
                nib <= shift[7:4];
            end else if (state == EMIT_HI && !quiet_q) begin
                nib <= byte_out[3:0];
            end
        end
    end

endmodule

// File: tb/tb_ps2_rx_nibbler.sv
// Testbench for ps2_rx_nibbler: drives PS/2 frames on the pins, predicts the
// output strobes per frame and compares the DUT against that prediction.
module tb_ps2_rx_nibbler;

    localparam int unsigned FL  = 4;
    localparam int unsigned TMO = 200;
    localparam int          H   = 12;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [7:0] byte_out;
    logic       byte_valid;
    logic [3:0] nib;
    logic       nib_valid;
    logic       err_parity;
    logic       err_frame;

    always #5 clk = ~clk;

    ps2_rx_nibbler #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TMO)) dut (
        .clk        (clk),
        .rst        (rst),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .byte_out   (byte_out),
        .byte_valid (byte_valid),
        .nib        (nib),
        .nib_valid  (nib_valid),
        .err_parity (err_parity),
        .err_frame  (err_frame)
    );

    typedef struct {
        logic       bv;
        logic [7:0] b;
        logic       nv;
        logic [3:0] n;
        logic       ep;
        logic       ef;
        logic       follow;
    } rec_t;

    rec_t       exp_q[$];
    logic       m_sup = 1'b0;
    logic [7:0] m_byte = '0;
    logic [3:0] m_nib = '0;
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         n_bv = 0, n_nv = 0, n_ep = 0, n_ef = 0;
    int         bv_cyc = 0, c_stop = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, req, $time);
        end
    endtask

    // Frame-level prediction of the strobe cycles a frame must produce.
    function automatic void model_frame(input logic [7:0] b, input logic par, input logic stop);
        rec_t r;
        logic quiet;
        r = '{default: '0};
        if (!stop) begin
            r.ef = 1'b1;
            exp_q.push_back(r);
        end else if ((^b ^ par) != 1'b1) begin
            r.ep = 1'b1;
            exp_q.push_back(r);
        end else begin
`ifdef PS2_RX_BREAK_FILTER_EN
            quiet = m_sup || (b == 8'hF0);
            m_sup = (b == 8'hF0);
`else
            quiet = 1'b0;
`endif
            r.bv = 1'b1;
            r.b  = b;
            r.nv = !quiet;
            r.n  = b[7:4];
            exp_q.push_back(r);
            if (!quiet) begin
                r = '{default: '0};
                r.nv     = 1'b1;
                r.n      = b[3:0];
                r.follow = 1'b1;
                exp_q.push_back(r);
            end
        end
    endfunction

    // Per-cycle compare against the predicted strobe sequence and hold values.
    initial begin : cmp
        logic        rs;
        rec_t        r;
        int          last;
        logic [15:0] act;
        last = -10;
        forever begin
            @(posedge clk);
            rs = rst;
            @(negedge clk);
            act = {byte_valid, nib_valid, err_parity, err_frame, byte_out, nib};
            if (rs) begin
                m_byte = '0;
                m_nib  = '0;
                chk("reset_outputs", act, 32'h0);
            end else if (byte_valid | nib_valid | err_parity | err_frame) begin
                if (byte_valid) begin n_bv++; bv_cyc = cyc; end
                if (nib_valid)  n_nv++;
                if (err_parity) n_ep++;
                if (err_frame)  n_ef++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_strobe", act, {4'b0000, m_byte, m_nib});
                end else begin
                    r = exp_q.pop_front();
                    if (r.follow) chk("nib_lo_follow", cyc - last, 1);
                    last = cyc;
                    if (r.bv) m_byte = r.b;
                    if (r.nv) m_nib = r.n;
                    chk("strobe", act, {r.bv, r.nv, r.ep, r.ef, m_byte, m_nib});
                end
            end else begin
                if (exp_q.size() > 0 && exp_q[0].follow && cyc == last + 1) begin
                    chk("nib_lo_missing", nib_valid, 1);
                    void'(exp_q.pop_front());
                end
                chk("hold", {byte_out, nib}, {m_byte, m_nib});
            end
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bits(input logic [10:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            ps2_data = bits[i];
            wait_cyc(H);
            ps2_clk = 1'b0;
            if (i == 10) c_stop = cyc;
            wait_cyc(H);
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
    endtask

    task automatic wait_drain(input int budget);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < budget) begin
            @(posedge clk);
            k++;
        end
        if (exp_q.size() != 0) begin
            chk("drain", exp_q.size(), 0);
            exp_q.delete();
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic par, input logic stop);
        model_frame(b, par, stop);
        send_bits({stop, par, b, 1'b0}, 11);
        wait_cyc(30);
        wait_drain(60);
        // Two sync flops, FILTER_LEN filter samples, then EMIT_HI one cycle later.
        if (stop && (^b ^ par)) chk("latency", bv_cyc - c_stop, FL + 3);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        wait_cyc(2);
        rst = 1'b0;
        m_sup = 1'b0;
        wait_cyc(5);
    endtask

    initial begin : main
        int bv0, nv0, ep0, ef0;
        logic [7:0] b;
        int kind;
        logic par, stop;

        wait_cyc(2);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_literal", {byte_valid, nib_valid, err_parity, err_frame, byte_out, nib}, 32'h0);
        wait_cyc(5);

        // Make code 0x1C
        bv0 = n_bv; nv0 = n_nv; ep0 = n_ep; ef0 = n_ef;
        send_frame(8'h1C, 1'b0, 1'b1);
        @(negedge clk);
        chk("make_byte", byte_out, 8'h1C);
        chk("make_nib", nib, 4'hC);
        chk("make_counts", {n_bv - bv0, n_nv - nv0, n_ep - ep0, n_ef - ef0}, {32'd1, 32'd2, 32'd0, 32'd0});

        // Parity error
        bv0 = n_bv; nv0 = n_nv; ep0 = n_ep;
        send_frame(8'h1C, 1'b1, 1'b1);
        @(negedge clk);
        chk("parity_pulse", n_ep - ep0, 1);
        chk("parity_no_valid", (n_bv - bv0) + (n_nv - nv0), 0);
        chk("parity_byte_kept", byte_out, 8'h1C);

        // Stop-bit error
        bv0 = n_bv; ef0 = n_ef;
        send_frame(8'h29, 1'b0, 1'b0);
        chk("stop_pulse", n_ef - ef0, 1);
        chk("stop_no_valid", n_bv - bv0, 0);

        // Timeout after start + 3 data bits
        ef0 = n_ef;
        model_frame(8'h00, 1'b1, 1'b0);
        send_bits({1'b1, 1'b0, 8'h5A, 1'b0}, 4);
        wait_cyc(TMO + 10);
        wait_drain(60);
        chk("timeout_pulse", n_ef - ef0, 1);
        nv0 = n_nv;
        send_frame(8'h5A, 1'b1, 1'b1);
        @(negedge clk);
        chk("after_timeout_nib", nib, 4'hA);
        chk("after_timeout_nv", n_nv - nv0, 2);

        // Short low glitch on ps2_clk with data low while idle
        ps2_data = 1'b0;
        ps2_clk  = 1'b0;
        wait_cyc(2);
        ps2_clk  = 1'b1;
        wait_cyc(10);
        ps2_data = 1'b1;
        wait_cyc(20);
        nv0 = n_nv;
        send_frame(8'h1C, 1'b0, 1'b1);
        chk("after_glitch_nv", n_nv - nv0, 2);

        // Reset in the middle of a frame, then a fresh frame
        ep0 = n_ep; ef0 = n_ef; nv0 = n_nv;
        send_bits({1'b1, 1'b0, 8'h1C, 1'b0}, 6);
        do_reset();
        send_frame(8'h1C, 1'b0, 1'b1);
        chk("midreset_errs", (n_ep - ep0) + (n_ef - ef0), 0);
        chk("midreset_nv", n_nv - nv0, 2);

        // Break prefix sequence
        do_reset();
        bv0 = n_bv; nv0 = n_nv;
        send_frame(8'hF0, 1'b1, 1'b1);
        send_frame(8'h1C, 1'b0, 1'b1);
        send_frame(8'h1C, 1'b0, 1'b1);
        chk("break_bv", n_bv - bv0, 3);
`ifdef PS2_RX_BREAK_FILTER_EN
        chk("break_nv", n_nv - nv0, 2);
`else
        chk("break_nv", n_nv - nv0, 6);
`endif

        // Random frames: mostly good, some parity and stop errors
        for (int k = 0; k < 40; k++) begin
            b    = 8'($urandom);
            kind = int'($urandom_range(0, 9));
            par  = ~^b;
            stop = 1'b1;
            if (kind == 0) par = ~par;
            if (kind == 1) stop = 1'b0;
            send_frame(b, par, stop);
            wait_cyc(int'($urandom_range(0, 20)));
        end

        wait_drain(60);
        chk("queue_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #(10 * 90000);
        errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule
